// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer for a 2^AW x DW combinational
// instruction memory. It owns the PC, captures fetched words into a 2-entry
// buffer, presents the head over valid/ready, flushes on redirect and stops
// fetching once the halt word is captured.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | reset state, waiting for start; redirect ignored
//   S_FETCH | capturing one word per edge whenever a buffer slot is free
//   S_HALT  | halt word captured; no capture, buffer drains, redirect resumes
module ifetch_ctrl #(
  parameter int AW = 4,
  parameter int DW = 32,
  parameter logic [DW-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] ins_out,
  output logic [AW-1:0] ins_pc,
  output logic          ins_valid,
  input  logic          ins_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    cnt_q, cnt_d;
  // Entry 0 is the head; unused entries are kept at zero so the outputs
  // read 0 whenever the buffer is empty.
  logic [DW-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic [AW-1:0] adr0_q, adr0_d, adr1_q, adr1_d;

  logic          pop;
  logic          cap;
  logic          flush;
  logic [1:0]    cnt_tmp;

  // Next-state, PC and buffer update: pop first, then append the capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
    adr0_d  = adr0_q;
    adr1_d  = adr1_q;
    cap     = 1'b0;
    flush   = 1'b0;
    cnt_tmp = cnt_q;
    pop     = (cnt_q != 2'd0) && ins_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
        end else if ((cnt_q != 2'd2) || pop) begin
          cap = 1'b1;
          if (imem_data == HALT_WORD) begin
            state_d = S_HALT;
          end else begin
            pc_d = AW'(pc_q + 1'b1);
          end
        end
      end
      S_HALT: begin
        if (redirect) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      cnt_d  = 2'd0;
      dat0_d = '0;
      dat1_d = '0;
      adr0_d = '0;
      adr1_d = '0;
    end else begin
      if (pop) begin
        dat0_d  = dat1_q;
        adr0_d  = adr1_q;
        dat1_d  = '0;
        adr1_d  = '0;
        cnt_tmp = 2'(cnt_q - 2'd1);
      end
      if (cap) begin
        if (cnt_tmp == 2'd0) begin
          dat0_d = imem_data;
          adr0_d = pc_q;
        end else begin
          dat1_d = imem_data;
          adr1_d = pc_q;
        end
        cnt_tmp = 2'(cnt_tmp + 2'd1);
      end
      cnt_d = cnt_tmp;
    end
  end

  // State, PC and buffer registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= 2'd0;
      dat0_q  <= '0;
      dat1_q  <= '0;
      adr0_q  <= '0;
      adr1_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
      adr0_q  <= adr0_d;
      adr1_q  <= adr1_d;
    end
  end

  assign imem_addr = pc_q;
  assign ins_valid = (cnt_q != 2'd0);
  assign ins_out   = dat0_q;
  assign ins_pc    = adr0_q;
  assign halted    = (state_q == S_HALT);
  assign busy      = (state_q == S_FETCH);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch sequencer.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ins_out;
  logic [3:0]  ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [3:0]  redirect_pc;
  logic        halted;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  assign imem_data = mem[imem_addr];

  ifetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ins_out(ins_out), .ins_pc(ins_pc), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 fetching, 2 halted; buffer is a queue.
  typedef struct {
    logic [3:0]  pc;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_state;
  int   m_pc;

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_pc    = 0;
  endtask

  task automatic model_step(input bit st, input bit rd, input int rpc, input bit rdy);
    ent_t e;
    bit   popped;
    popped = (mq.size() > 0) && rdy;
    e.pc   = 4'(m_pc);
    e.data = mem[m_pc];
    if (m_state == 0) begin
      if (st) begin
        m_state = 1;
        m_pc    = 0;
      end
    end else begin
      if (popped) void'(mq.pop_front());
      if (rd) begin
        mq.delete();
        m_pc    = rpc;
        m_state = 1;
      end else if (m_state == 1 && mq.size() < 2) begin
        mq.push_back(e);
        if (e.data == 32'hFFFF_FFFF) m_state = 2;
        else m_pc = (m_pc + 1) % 16;
      end
    end
  endtask

  task automatic tick(input bit st, input bit rd, input int rpc, input bit rdy);
    start       = st;
    redirect    = rd;
    redirect_pc = 4'(rpc);
    ins_ready   = rdy;
    model_step(st, rd, rpc, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; redirect = 0; redirect_pc = 0; ins_ready = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * i;
    mem[0]  = 32'h0F0F_0F0F;
    mem[1]  = 32'h0000_FFFF;
    mem[4]  = 32'h7777_7777;
    mem[15] = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ins_valid, ins_out, ins_pc, imem_addr, halted, busy} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b out=%h pc=%0d addr=%0d h=%b b=%b, want all 0",
               ins_valid, ins_out, ins_pc, imem_addr, halted, busy);
    end
  endtask

  task automatic test_stream();
    do_reset();
    tick(1, 0, 0, 1);
    checks++;
    if ({busy, ins_valid, imem_addr} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL stream_start: got busy=%b v=%b addr=%0d want 1 0 0", busy, ins_valid, imem_addr);
    end
    for (int k = 0; k < 16; k++) begin
      tick(0, 0, 0, 1);
      checks++;
      if ({ins_valid, ins_pc} !== {1'b1, 4'(k)}) begin
        errors++;
        $display("FAIL stream_pc: got v=%b pc=%0d want v=1 pc=%0d", ins_valid, ins_pc, k);
      end
      if (k == 0 || k == 1 || k == 15) begin
        checks++;
        if (ins_out !== mem[k]) begin
          errors++;
          $display("FAIL stream_data: pc %0d got %h want %h", k, ins_out, mem[k]);
        end
      end
    end
    checks++;
    if ({halted, busy, imem_addr} !== {1'b1, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL stream_halt: got h=%b b=%b addr=%0d want 1 0 15", halted, busy, imem_addr);
    end
    tick(0, 0, 0, 1);
    checks++;
    if ({ins_valid, halted, imem_addr} !== {1'b0, 1'b1, 4'd15}) begin
      errors++;
      $display("FAIL stream_drained: got v=%b h=%b addr=%0d want 0 1 15", ins_valid, halted, imem_addr);
    end
  endtask

  // Continues from the halted, drained state left by test_stream.
  task automatic test_halt_redirect();
    tick(0, 1, 15, 1);
    checks++;
    if ({ins_valid, busy, halted, imem_addr} !== {1'b0, 1'b1, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL halt_redir15: got v=%b b=%b h=%b addr=%0d want 0 1 0 15", ins_valid, busy, halted, imem_addr);
    end
    tick(0, 0, 0, 1);
    checks++;
    if ({ins_valid, ins_pc, ins_out, halted, imem_addr} !== {1'b1, 4'd15, 32'hFFFF_FFFF, 1'b1, 4'd15}) begin
      errors++;
      $display("FAIL halt_refetch: got v=%b pc=%0d out=%h h=%b addr=%0d want 1 15 ffffffff 1 15",
               ins_valid, ins_pc, ins_out, halted, imem_addr);
    end
    tick(0, 1, 14, 0);
    checks++;
    if ({ins_valid, busy, imem_addr} !== {1'b0, 1'b1, 4'd14}) begin
      errors++;
      $display("FAIL halt_redir14: got v=%b b=%b addr=%0d want 0 1 14", ins_valid, busy, imem_addr);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if ({ins_valid, ins_pc, halted, imem_addr} !== {1'b1, 4'd14, 1'b1, 4'd15}) begin
      errors++;
      $display("FAIL halt_two_buffered: got v=%b pc=%0d h=%b addr=%0d want 1 14 1 15", ins_valid, ins_pc, halted, imem_addr);
    end
    tick(0, 0, 0, 1);
    checks++;
    if ({ins_valid, ins_pc, ins_out, imem_addr} !== {1'b1, 4'd15, 32'hFFFF_FFFF, 4'd15}) begin
      errors++;
      $display("FAIL halt_pop1: got v=%b pc=%0d out=%h addr=%0d want 1 15 ffffffff 15", ins_valid, ins_pc, ins_out, imem_addr);
    end
    tick(0, 0, 0, 1);
    checks++;
    if ({ins_valid, halted, imem_addr} !== {1'b0, 1'b1, 4'd15}) begin
      errors++;
      $display("FAIL halt_nowrap: got v=%b h=%b addr=%0d want 0 1 15", ins_valid, halted, imem_addr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++;
    if ({ins_valid, ins_pc, imem_addr} !== {1'b1, 4'd0, 4'd2}) begin
      errors++;
      $display("FAIL bp_full: got v=%b pc=%0d addr=%0d want 1 0 2", ins_valid, ins_pc, imem_addr);
    end
    tick(0, 0, 0, 0);
    checks++;
    if ({ins_valid, ins_pc, imem_addr} !== {1'b1, 4'd0, 4'd2}) begin
      errors++;
      $display("FAIL bp_hold: got v=%b pc=%0d addr=%0d want 1 0 2", ins_valid, ins_pc, imem_addr);
    end
    for (int k = 1; k <= 3; k++) begin
      tick(0, 0, 0, 1);
      checks++;
      if ({ins_valid, ins_pc} !== {1'b1, 4'(k)}) begin
        errors++;
        $display("FAIL bp_release: got v=%b pc=%0d want 1 %0d", ins_valid, ins_pc, k);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    checks++;
    if ({ins_valid, ins_pc} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL redir_pre: got v=%b pc=%0d want 1 1", ins_valid, ins_pc);
    end
    tick(0, 1, 4, 1);
    checks++;
    if ({ins_valid, ins_out, ins_pc, imem_addr} !== {1'b0, 32'd0, 4'd0, 4'd4}) begin
      errors++;
      $display("FAIL redir_flush: got v=%b out=%h pc=%0d addr=%0d want 0 0 0 4", ins_valid, ins_out, ins_pc, imem_addr);
    end
    tick(0, 0, 0, 1);
    checks++;
    if ({ins_valid, ins_pc, ins_out} !== {1'b1, 4'd4, 32'h7777_7777}) begin
      errors++;
      $display("FAIL redir_target: got v=%b pc=%0d out=%h want 1 4 77777777", ins_valid, ins_pc, ins_out);
    end
    for (int k = 5; k <= 6; k++) begin
      tick(0, 0, 0, 1);
      checks++;
      if ({ins_valid, ins_pc} !== {1'b1, 4'(k)}) begin
        errors++;
        $display("FAIL redir_follow: got v=%b pc=%0d want 1 %0d", ins_valid, ins_pc, k);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ins_valid, ins_out, ins_pc, imem_addr, halted, busy} !== 42'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b out=%h pc=%0d addr=%0d h=%b b=%b want all 0",
               ins_valid, ins_out, ins_pc, imem_addr, halted, busy);
    end
    #1 rst = 1'b0;
    model_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    checks++;
    if ({busy, ins_valid, imem_addr} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL async_stays_idle: got b=%b v=%b addr=%0d want 0 0 0", busy, ins_valid, imem_addr);
    end
    tick(1, 0, 0, 1);
    tick(0, 0, 0, 1);
    checks++;
    if ({ins_valid, ins_pc} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL async_restart: got v=%b pc=%0d want 1 0", ins_valid, ins_pc);
    end
  endtask

  task automatic test_idle_redirect();
    do_reset();
    tick(0, 1, 9, 1);
    tick(0, 1, 9, 1);
    checks++;
    if ({busy, ins_valid, imem_addr, halted} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL idle_redirect: got b=%b v=%b addr=%0d h=%b want 0 0 0 0", busy, ins_valid, imem_addr, halted);
    end
    tick(1, 1, 9, 1);
    checks++;
    if ({busy, imem_addr} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL idle_start_wins: got b=%b addr=%0d want 1 0", busy, imem_addr);
    end
    tick(0, 0, 0, 1);
    checks++;
    if ({ins_valid, ins_pc, ins_out} !== {1'b1, 4'd0, 32'h0F0F_0F0F}) begin
      errors++;
      $display("FAIL idle_first_pc: got v=%b pc=%0d out=%h want 1 0 0f0f0f0f", ins_valid, ins_pc, ins_out);
    end
  endtask

  task automatic test_random();
    logic [44:0] exp_v;
    logic [44:0] got_v;
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);
      if (mq.size() > 0)
        exp_v = {1'b1, mq[0].pc, mq[0].data, 4'(m_pc), m_state == 2, m_state == 1};
      else
        exp_v = {1'b0, 4'd0, 32'd0, 4'(m_pc), m_state == 2, m_state == 1};
      got_v = {ins_valid, ins_pc, ins_out, imem_addr, halted, busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle %0d: got {v,pc,out,addr,h,b}=%h want %h", n, got_v, exp_v);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    init_mem();
    test_reset();
    test_stream();
    test_halt_redirect();
    test_backpressure();
    test_redirect();
    test_async_reset();
    test_idle_redirect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
